uart_rx_ctrl: RTL

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: supervises a UART receiver. It detects line idle after each
// frame, applies parity/prescale changes only while the line is idle, and
// buffers received bytes in a small FIFO with sticky overrun reporting.
// Optional error counters are built when UART_RX_CTRL_ERR_CNT_EN is defined.
module uart_rx_ctrl #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned RST_PRESCALE = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       cfg_wr,
  input  logic       cfg_par_en,
  input  logic       cfg_par_typ,
  input  logic [5:0] cfg_prescale,
  output logic       cfg_busy,
  output logic       PAR_EN,
  output logic       PAR_TYP,
  output logic [5:0] Prescale,
  input  logic       RX_IN,
  input  logic [7:0] rx_p_data,
  input  logic       rx_data_valid,
  input  logic       rx_parity_error,
  input  logic       rx_stop_error,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overrun,
  input  logic       err_clr
`ifdef UART_RX_CTRL_ERR_CNT_EN
  ,
  output logic [7:0] par_err_cnt,
  output logic [7:0] stop_err_cnt,
  output logic [7:0] ovr_cnt
`endif
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    GUARD = 2'd0,
    IDLE  = 2'd1,
    FRAME = 2'd2
  } state_t;

  typedef struct packed {
    logic       par_en;
    logic       par_typ;
    logic [5:0] prescale;
  } cfg_t;

  state_t        state_q, state_d;
  logic [5:0]    idle_cnt_q, idle_cnt_d;
  logic          par_prev_q, stop_prev_q;
  logic          par_rise_c, stop_rise_c, frame_end_c;
  cfg_t          pend_q;
  logic          apply_c;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_c, push_c, pop_c, drop_c;
  logic [7:0]    head_d;

  assign par_rise_c  = rx_parity_error & ~par_prev_q;
  assign stop_rise_c = rx_stop_error & ~stop_prev_q;
  assign frame_end_c = rx_data_valid | par_rise_c | stop_rise_c;
  assign apply_c     = cfg_busy && (state_q == IDLE);

  // State and idle counter registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= GUARD;
      idle_cnt_q <= 6'd0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  // Next state: wait one idle bit time after each frame before arming IDLE
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    case (state_q)
      GUARD: begin
        if (!RX_IN) begin
          idle_cnt_d = 6'd0;
        end else if (idle_cnt_q == Prescale - 6'd1) begin
          state_d    = IDLE;
          idle_cnt_d = 6'd0;
        end else begin
          idle_cnt_d = idle_cnt_q + 6'd1;
        end
      end
      IDLE: begin
        if (!RX_IN) state_d = FRAME;
      end
      FRAME: begin
        if (frame_end_c) begin
          state_d    = GUARD;
          idle_cnt_d = 6'd0;
        end
      end
      default: begin
        state_d    = GUARD;
        idle_cnt_d = 6'd0;
      end
    endcase
  end

  // Previous error levels for rising-edge detection
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_prev_q  <= 1'b0;
      stop_prev_q <= 1'b0;
    end else begin
      par_prev_q  <= rx_parity_error;
      stop_prev_q <= rx_stop_error;
    end
  end

  // Pending/applied configuration; a write on the apply edge stays pending
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pend_q   <= '0;
      cfg_busy <= 1'b0;
      PAR_EN   <= 1'b0;
      PAR_TYP  <= 1'b0;
      Prescale <= 6'(RST_PRESCALE);
    end else begin
      if (apply_c) begin
        PAR_EN   <= pend_q.par_en;
        PAR_TYP  <= pend_q.par_typ;
        Prescale <= pend_q.prescale;
        cfg_busy <= cfg_wr;
      end else if (cfg_wr) begin
        cfg_busy <= 1'b1;
      end
      if (cfg_wr) begin
        pend_q.par_en   <= cfg_par_en;
        pend_q.par_typ  <= cfg_par_typ;
        pend_q.prescale <= cfg_prescale;
      end
    end
  end

  assign full_c = (count_q == CW'(FIFO_DEPTH));
  assign pop_c  = out_valid & out_ready;
  assign push_c = rx_data_valid & (~full_c | pop_c);
  assign drop_c = rx_data_valid & full_c & ~pop_c;

  // FIFO occupancy, read pointer and next head byte
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (pop_c) rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_c && (rd_ptr_d == wr_ptr_q)) head_d = rx_p_data;
    else                                  head_d = mem_q[rd_ptr_d];
  end

  // FIFO storage, pointers and registered head outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= 8'd0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      out_valid <= 1'b0;
      out_data  <= 8'd0;
    end else begin
      if (push_c) begin
        mem_q[wr_ptr_q] <= rx_p_data;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      out_valid <= (count_d != '0);
      out_data  <= head_d;
    end
  end

  // Sticky overrun; clear takes priority over a coincident drop
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)         overrun <= 1'b0;
    else if (err_clr) overrun <= 1'b0;
    else if (drop_c)  overrun <= 1'b1;
  end

`ifdef UART_RX_CTRL_ERR_CNT_EN
  // Saturating error counters; clear takes priority over increment
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_err_cnt  <= 8'd0;
      stop_err_cnt <= 8'd0;
      ovr_cnt      <= 8'd0;
    end else if (err_clr) begin
      par_err_cnt  <= 8'd0;
      stop_err_cnt <= 8'd0;
      ovr_cnt      <= 8'd0;
    end else begin
      if (par_rise_c && (par_err_cnt != 8'hFF))   par_err_cnt  <= par_err_cnt + 8'd1;
      if (stop_rise_c && (stop_err_cnt != 8'hFF)) stop_err_cnt <= stop_err_cnt + 8'd1;
      if (drop_c && (ovr_cnt != 8'hFF))           ovr_cnt      <= ovr_cnt + 8'd1;
    end
  end
`endif

endmodule
